// File: rtl/avalon_mm_mult_responder.sv
// Avalon-MM responder for the multiply link: operand/result register file with
// 1-cycle registered reads, plus a sequential shift-add multiplier (SZ cycles per START).
module avalon_mm_mult_responder #(
  parameter int unsigned SZ  = 32,
  parameter int unsigned DSZ = 16,
  parameter int unsigned ASZ = 4
) (
  input  logic           clk,
  input  logic           _rst,
  input  logic [ASZ-1:0] addr,
  input  logic           read,
  input  logic           write,
  input  logic [DSZ-1:0] write_data,
  output logic [DSZ-1:0] read_data,
  output logic           read_valid,
  output logic           busy
);

  localparam int unsigned PSZ = 2 * SZ;
  localparam int unsigned CW  = $clog2(SZ + 1);

  if (SZ != 2 * DSZ) begin : g_size_chk
    $error("avalon_mm_mult_responder: SZ must equal 2*DSZ");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [SZ-1:0]   a_q;
  logic [SZ-1:0]   b_q;
  logic [PSZ-1:0]  res_q;
  logic [PSZ-1:0]  acc_q;
  logic [PSZ-1:0]  mcand_q;
  logic [SZ-1:0]   mplier_q;
  logic [CW-1:0]   cnt_q;
  logic [DSZ-1:0]  read_data_q;
  logic            read_valid_q;
  logic            busy_q;

  logic [PSZ-1:0]  acc_d;
  logic [DSZ-1:0]  rd_word_c;

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign busy       = busy_q;

  // Partial-product add; the multiplicand register carries the <<(SZ-cnt) shift.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  // Read-data mux; anything not mapped (including write-only CTRL) reads as zero.
  always_comb begin
    rd_word_c = '0;
    case (addr)
      ASZ'(4'h0): rd_word_c = a_q[DSZ-1:0];
      ASZ'(4'h1): rd_word_c = a_q[SZ-1:DSZ];
      ASZ'(4'h2): rd_word_c = b_q[DSZ-1:0];
      ASZ'(4'h3): rd_word_c = b_q[SZ-1:DSZ];
      ASZ'(4'h5): rd_word_c = DSZ'({(state_q == DONE), (state_q == BUSY)});
      ASZ'(4'h8): rd_word_c = res_q[0*DSZ +: DSZ];
      ASZ'(4'h9): rd_word_c = res_q[1*DSZ +: DSZ];
      ASZ'(4'hA): rd_word_c = res_q[2*DSZ +: DSZ];
      ASZ'(4'hB): rd_word_c = res_q[3*DSZ +: DSZ];
      default:    rd_word_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // A read coinciding with a write is dropped; read_data holds otherwise.
      read_valid_q <= 1'b0;
      if (read && !write) begin
        read_data_q  <= rd_word_c;
        read_valid_q <= 1'b1;
      end

      case (state_q)
        IDLE, DONE: begin
          if (write) begin
            case (addr)
              ASZ'(4'h0): begin a_q[DSZ-1:0]  <= write_data; state_q <= IDLE; end
              ASZ'(4'h1): begin a_q[SZ-1:DSZ] <= write_data; state_q <= IDLE; end
              ASZ'(4'h2): begin b_q[DSZ-1:0]  <= write_data; state_q <= IDLE; end
              ASZ'(4'h3): begin b_q[SZ-1:DSZ] <= write_data; state_q <= IDLE; end
              ASZ'(4'h4): begin
                if (write_data[0]) begin
                  mcand_q  <= PSZ'(a_q);
                  mplier_q <= b_q;
                  acc_q    <= '0;
                  cnt_q    <= CW'(SZ);
                  state_q  <= BUSY;
                  busy_q   <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end

        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            res_q   <= acc_d;
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mm_mult_responder.sv
// Directed bench for avalon_mm_mult_responder: reads push expected words into a
// scoreboard queue, a negedge monitor pops and compares whenever read_valid is seen.
module tb_avalon_mm_mult_responder;

  logic        clk = 1'b0;
  logic        _rst;
  logic [3:0]  addr;
  logic        read;
  logic        write;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        read_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  avalon_mm_mult_responder #(.SZ(32), .DSZ(16), .ASZ(4)) dut (
    .clk        (clk),
    ._rst       (_rst),
    .addr       (addr),
    .read       (read),
    .write      (write),
    .write_data (write_data),
    .read_data  (read_data),
    .read_valid (read_valid),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    addr = a; write_data = d; write = 1'b1; read = 1'b0;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e);
    exp_t x;
    x.a = a; x.d = e;
    exp_q.push_back(x);
    addr = a; read = 1'b1; write = 1'b0;
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  task automatic rw(input logic [3:0] a, input logic [15:0] d);
    addr = a; write_data = d; write = 1'b1; read = 1'b1;
    @(posedge clk); #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: every read_valid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (read_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read_valid: got data 0x%0h required no response", read_data);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check($sformatf("read_addr_%0h", x.a), 32'(read_data), 32'(x.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    _rst = 1'b0; addr = '0; read = 1'b0; write = 1'b0; write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_read_data", 32'(read_data), 32'd0);
    check("rst_read_valid", 32'(read_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    _rst = 1'b1;
    @(posedge clk); #1;
    rd(4'h5, 16'h0000);

    // 10234 * 566 = 5792444 = 0x0058_62BC
    wr(4'h0, 16'h27FA); wr(4'h1, 16'h0000); wr(4'h2, 16'h0236); wr(4'h3, 16'h0000);
    wr(4'h4, 16'h0001);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    wait_idle(n);
    check("t1_busy_cycles", 32'(n), 32'd32);
    rd(4'h5, 16'h0002);
    rd(4'h8, 16'h62BC); rd(4'h9, 16'h0058); rd(4'hA, 16'h0000); rd(4'hB, 16'h0000);

    // 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
    wr(4'h0, 16'hFFFF); wr(4'h1, 16'hFFFF); wr(4'h2, 16'hFFFF); wr(4'h3, 16'hFFFF);
    wr(4'h4, 16'h0001);
    wait_idle(n);
    check("t2_busy_cycles", 32'(n), 32'd32);
    rd(4'h8, 16'h0001); rd(4'h9, 16'h0000); rd(4'hA, 16'hFFFE); rd(4'hB, 16'hFFFF);

    // Multiply by zero takes the full SZ cycles; operands untouched
    wr(4'h0, 16'h5678); wr(4'h1, 16'h1234); wr(4'h2, 16'h0000); wr(4'h3, 16'h0000);
    wr(4'h4, 16'h0001);
    wait_idle(n);
    check("t3_busy_cycles", 32'(n), 32'd32);
    rd(4'h8, 16'h0000); rd(4'h9, 16'h0000); rd(4'hA, 16'h0000); rd(4'hB, 16'h0000);
    rd(4'h0, 16'h5678); rd(4'h1, 16'h1234);

    // 0x0003_0007 * 5 = 0x000F_0023; writes and START during BUSY are ignored
    wr(4'h0, 16'h0007); wr(4'h1, 16'h0003); wr(4'h2, 16'h0005); wr(4'h3, 16'h0000);
    wr(4'h4, 16'h0001);
    wr(4'h0, 16'hFFFF);
    wr(4'h4, 16'h0001);
    rd(4'h0, 16'h0007);
    rd(4'h8, 16'h0000);
    rd(4'h5, 16'h0001);
    wait_idle(n);
    check("t4_busy_remaining", 32'(n), 32'd27);
    rd(4'h8, 16'h0023); rd(4'h9, 16'h000F); rd(4'hA, 16'h0000); rd(4'hB, 16'h0000);
    rd(4'h5, 16'h0002);
    // Operand write in DONE returns to IDLE, result retained; START with bit0=0 is a no-op
    wr(4'h2, 16'h0005);
    rd(4'h5, 16'h0000);
    rd(4'h8, 16'h0023);
    wr(4'h4, 16'h0000);
    check("t4_ctrl_zero_busy", 32'(busy), 32'd0);
    rd(4'h5, 16'h0000);

    // Asynchronous reset in the middle of a multiply
    wr(4'h0, 16'hFFFF); wr(4'h1, 16'hFFFF);
    wr(4'h4, 16'h0001);
    rd(4'h0, 16'hFFFF);
    repeat (8) begin @(posedge clk); #1; end
    check("t5_busy_before_rst", 32'(busy), 32'd1);
    #2 _rst = 1'b0;
    #1;
    check("t5_rst_read_data", 32'(read_data), 32'd0);
    check("t5_rst_read_valid", 32'(read_valid), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    _rst = 1'b1;
    @(posedge clk); #1;
    rd(4'h5, 16'h0000);
    rd(4'h8, 16'h0000); rd(4'h9, 16'h0000); rd(4'hA, 16'h0000); rd(4'hB, 16'h0000);
    rd(4'h0, 16'h0000); rd(4'h1, 16'h0000);

    // Simultaneous read+write: write wins, no response; unmapped read gives 0
    rw(4'h0, 16'hABCD);
    check("t6_rw_no_valid", 32'(read_valid), 32'd0);
    rd(4'h0, 16'hABCD);
    rd(4'h7, 16'h0000);
    rd(4'h4, 16'h0000);
    repeat (3) begin @(posedge clk); #1; end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("idle_read_valid", 32'(read_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
